axi_rx_ml: RTL and testbench
============================

# axi_rx_ml

Multi-lane, parametrised successor to the single-lane serial packet receiver. Deserialises a `LANES`-bit-wide qualified serial stream into `packet_length`-bit words, MSB- or LSB-first, and buffers completed words in an internal first-word-fall-through FIFO with a valid/ready output toward the downstream FIFO/AXI-stream consumer. Single-clock design: the serial source is already synchronous to `aclk`. Overflow drops whole packets and counts them.

## Interface
- `packet_length`, 32, bits per packet; must be a multiple of `LANES`.
- `LANES`, 1, serial data bits accepted per beat; 1, 2, 4 or 8.
- `DEPTH`, 4, FIFO depth in packets; power of two, ≥2.
- `MSB_FIRST`, 1, 1 = first received bit lands in bit `packet_length-1`; 0 = first bit lands in bit 0.
- `CNT_W`, 16, width of the drop counter.

Ports:
- `aclk` in 1: sole clock, rising edge.
- `aresetn` in 1: reset, synchronous, active-low.
- `sdata` in `LANES`: serial beat data.
- `svalid` in 1: beat qualifier; `sdata` is sampled on every `aclk` edge where `svalid`=1.
- `fifo_data` out `packet_length`: head-of-FIFO word.
- `fifo_valid` out 1: FIFO not empty.
- `fifo_ready` in 1: consumer accepts head word when `fifo_valid`&`fifo_ready`.
- `overflow` out 1: one-cycle pulse when a completed packet is dropped.
- `drop_count` out `CNT_W`: saturating count of dropped packets.
- `level` out `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- BEATS = `packet_length`/`LANES`. Beat counter 0..BEATS-1 advances only on `svalid`=1; `svalid`=0 pauses assembly (no timeout, no abort), counter and shift register hold.
- MSB_FIRST=1: shift left by `LANES`, new beat in low bits; within a beat `sdata[LANES-1]` is the earlier/more significant bit. MSB_FIRST=0: shift right by `LANES`, new beat in high bits; `sdata[0]` is the earlier bit.
- On the beat with counter = BEATS-1, the completed word (including that beat) is offered to the FIFO on the same edge; counter wraps to 0; the next beat starts a new packet with no dead cycle.
- Write accepted if FIFO not full, or if full and a pop occurs on the same edge. Otherwise packet dropped: `overflow` pulses 1 cycle, `drop_count` increments, saturating at all-ones. FIFO contents untouched.
- Pop on `fifo_valid`&`fifo_ready`; `fifo_ready` while empty is ignored. Simultaneous push/pop on empty FIFO: pushed word becomes visible next cycle, level stays 0→1 (pop ignored since empty).
- `fifo_data` is forced to 0 while `fifo_valid`=0.
- Read/write pointers wrap modulo DEPTH; `level` distinguishes full (DEPTH) from empty (0).

## Timing
- Reset (`aresetn`=0 at an edge): beat counter 0, shift register 0, FIFO empty, `fifo_valid`=0, `fifo_data`=0, `overflow`=0, `drop_count`=0, `level`=0. Reset mid-packet discards the partial packet; `svalid` ignored during reset.
- Latency: last beat sampled at edge N → `fifo_valid`=1 and word on `fifo_data` after edge N (visible in cycle N+1) if FIFO was empty.
- Throughput: one packet per BEATS cycles sustained; with `fifo_ready`=1 continuous, FIFO never exceeds 1 entry.
- `level` and `fifo_valid` update on the same edge as the push/pop causing them.
- `overflow` asserted exactly in the cycle after the dropping edge, low otherwise.

## Test plan
- LANES=1, MSB_FIRST=1: 32 beats of 0xA5C30F96 MSB-first, `fifo_ready`=1 → `fifo_data`=0xA5C30F96, `fifo_valid` high one cycle after last beat, then low.
- LANES=4, MSB_FIRST=0: 8 beats 0x6,0x9,0x1,0xF,0x0,0xC,0x3,0xA → `fifo_data`=0xA3C0F196.
- Gaps: LANES=1, `svalid` dropped for 3 cycles after beats 7 and 20 of 0x12345678 → same word 0x12345678, no extra packet.
- Overflow: DEPTH=4, `fifo_ready`=0, 5 packets 1..5 → `level`=4, one `overflow` pulse, `drop_count`=1; drain → 1,2,3,4 in order, `level`=0, `fifo_data`=0.
- Full + simultaneous pop: FIFO full, last beat of packet 6 coincides with a pop → no drop, `level` stays 4, output order 2,3,4,6.
- Reset mid-packet: 10 beats, `aresetn`=0 one cycle, then 32 beats of 0xDEADBEEF → exactly one word 0xDEADBEEF, `drop_count`=0.

Source files
------------

// File: rtl/axi_rx_ml.sv
// axi_rx_ml
// ---------------------------------------------------------------------------
// Multi-lane serial packet receiver. Qualified LANES-bit beats are shifted
// into a packet_length-bit word, MSB- or LSB-first. Completed words are
// buffered in a first-word-fall-through FIFO and offered downstream with
// valid/ready. A packet that completes while the FIFO is full, and no pop
// happens on that edge, is dropped whole. Each drop pulses overflow for one
// cycle and bumps a saturating counter.
//
// Ports
//   aclk        : sole clock, rising edge
//   aresetn     : synchronous active-low reset
//   sdata       : serial beat data (LANES bits)
//   svalid      : beat qualifier, sdata sampled when high
//   fifo_data   : head-of-FIFO word, zero while the FIFO is empty
//   fifo_valid  : FIFO not empty
//   fifo_ready  : consumer takes the head word when fifo_valid & fifo_ready
//   overflow    : one-cycle pulse after a completed packet was dropped
//   drop_count  : saturating count of dropped packets
//   level       : current FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module axi_rx_ml #(
  parameter int packet_length = 32,
  parameter int LANES         = 1,
  parameter int DEPTH         = 4,
  parameter int MSB_FIRST     = 1,
  parameter int CNT_W         = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [LANES-1:0]         sdata,
  input  logic                     svalid,
  output logic [packet_length-1:0] fifo_data,
  output logic                     fifo_valid,
  input  logic                     fifo_ready,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int BEATS = packet_length / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;

  logic [BCW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [packet_length-1:0] shift_q, shift_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic [CNT_W-1:0]         drop_count_q, drop_count_d;

  logic [packet_length-1:0] mem [DEPTH];

  logic [packet_length-1:0] shift_in;
  logic                     last_beat;
  logic                     full;
  logic                     pop;
  logic                     push;
  logic                     drop;

  // Shift register with the current beat merged in. This is the completed
  // word on the last beat, so the FIFO sees it on the same edge.
  generate
    if (BEATS == 1) begin : g_single_beat
      assign shift_in = sdata;
    end else if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = {shift_q[packet_length-LANES-1:0], sdata};
    end else begin : g_lsb_first
      assign shift_in = {sdata, shift_q[packet_length-1:LANES]};
    end
  endgenerate

  assign fifo_valid = (level_q != '0);
  assign full       = (level_q == LW'(DEPTH));
  assign last_beat  = svalid && (beat_cnt_q == BCW'(BEATS - 1));
  // fifo_ready on an empty FIFO is meaningless and must not move pointers.
  assign pop        = fifo_valid && fifo_ready;
  // A pop on the same edge frees the slot the new word needs.
  assign push       = last_beat && (!full || pop);
  assign drop       = last_beat && full && !pop;

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    shift_d      = shift_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = drop;
    drop_count_d = drop_count_q;

    if (svalid) begin
      shift_d    = shift_in;
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BCW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_cnt_q   <= '0;
      shift_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage needs no reset: fifo_data is masked while the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (aresetn && push) mem[wr_ptr_q] <= shift_in;
  end

  assign fifo_data  = fifo_valid ? mem[rd_ptr_q] : '0;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign level      = level_q;

endmodule

// File: tb/tb_axi_rx_ml.sv
// Testbench for axi_rx_ml. It uses two instances: a 1-lane MSB-first receiver
// and a 4-lane LSB-first receiver. Expected words are queued when the last
// beat is driven. They are popped and compared whenever the DUT hands a word
// to the consumer.
module tb_axi_rx_ml;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;

  // 1-lane, MSB-first instance
  logic        s1_data, s1_valid, r1;
  logic [31:0] f1_data;
  logic        f1_valid, ov1;
  logic [15:0] dc1;
  logic [2:0]  lv1;

  // 4-lane, LSB-first instance
  logic [3:0]  s4_data;
  logic        s4_valid, r4;
  logic [31:0] f4_data;
  logic        f4_valid, ov4;
  logic [15:0] dc4;
  logic [2:0]  lv4;

  axi_rx_ml #(.packet_length(32), .LANES(1), .DEPTH(4), .MSB_FIRST(1), .CNT_W(16)) u_dut1 (
    .aclk(clk), .aresetn(aresetn), .sdata(s1_data), .svalid(s1_valid),
    .fifo_data(f1_data), .fifo_valid(f1_valid), .fifo_ready(r1),
    .overflow(ov1), .drop_count(dc1), .level(lv1)
  );

  axi_rx_ml #(.packet_length(32), .LANES(4), .DEPTH(4), .MSB_FIRST(0), .CNT_W(16)) u_dut4 (
    .aclk(clk), .aresetn(aresetn), .sdata(s4_data), .svalid(s4_valid),
    .fifo_data(f4_data), .fifo_valid(f4_valid), .fifo_ready(r4),
    .overflow(ov4), .drop_count(dc4), .level(lv4)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q4[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: a transfer happens at the next edge when valid & ready.
  always @(negedge clk) begin
    if (aresetn && f1_valid && r1) begin
      chk("sb1_pending", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        chk("dut1_word", 64'(f1_data), 64'(q1.pop_front()));
        $display("dut1 pop 0x%08h", f1_data);
      end
    end
    if (aresetn && f4_valid && r4) begin
      chk("sb4_pending", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        chk("dut4_word", 64'(f4_data), 64'(q4.pop_front()));
        $display("dut4 pop 0x%08h", f4_data);
      end
    end
    // With the consumer always ready the 4-lane FIFO never holds more than one.
    if (aresetn && r4) chk("dut4_level_le1", 64'(lv4 <= 3'd1), 64'd1);
  end

  // Sends one 32-bit packet MSB-first to dut1. It can pause svalid for three
  // cycles after the beats ga/gb. If pop_last is set, it raises fifo_ready
  // together with the last beat. It returns with the last beat still on the bus.
  task automatic send1(input logic [31:0] w, input bit accept,
                       input int ga, input int gb, input bit pop_last);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      s1_valid = 1'b1;
      s1_data  = w[31-i];
      if (pop_last && i == 31) r1 = 1'b1;
      if (i == ga || i == gb) begin
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          s1_valid = 1'b0;
        end
      end
    end
    if (accept) q1.push_back(w);
    $display("dut1 send 0x%08h accept=%0d", w, accept);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      s4_valid = 1'b1;
      s4_data  = w[4*i +: 4];
    end
    q4.push_back(w);
    $display("dut4 send 0x%08h", w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s1_valid = 1'b0;
      s4_valid = 1'b0;
    end
  endtask

  task automatic drain1;
    @(posedge clk); #1;
    s1_valid = 1'b0;
    r1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lv1 == 3'd0) break;
    end
    chk("drain_level", 64'(lv1), 64'd0);
    chk("drain_valid", 64'(f1_valid), 64'd0);
    chk("drain_data_zero", 64'(f1_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [3:0] nib_tab [8];

  initial begin
    aresetn = 1'b0;
    s1_data = 1'b0; s1_valid = 1'b0; r1 = 1'b1;
    s4_data = 4'h0; s4_valid = 1'b0; r4 = 1'b1;
    nib_tab = '{4'h6, 4'h9, 4'h1, 4'hF, 4'h0, 4'hC, 4'h3, 4'hA};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(f1_valid), 64'd0);
    chk("rst_data", 64'(f1_data), 64'd0);
    chk("rst_level", 64'(lv1), 64'd0);
    chk("rst_drop", 64'(dc1), 64'd0);
    chk("rst_overflow", 64'(ov1), 64'd0);
    chk("rst_valid4", 64'(f4_valid), 64'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Single MSB-first packet: valid for exactly one cycle after the last beat.
    send1(32'hA5C30F96, 1'b1, -1, -1, 1'b0);
    @(posedge clk); #1;
    s1_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", 64'(f1_valid), 64'd1);
    chk("lat_data", 64'(f1_data), 64'hA5C30F96);
    @(negedge clk);
    chk("lat_valid_low", 64'(f1_valid), 64'd0);
    chk("lat_data_zero", 64'(f1_data), 64'd0);

    // 4-lane LSB-first: the fixed nibble sequence, then random words back-to-back.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      s4_valid = 1'b1;
      s4_data  = nib_tab[i];
    end
    q4.push_back(32'hA3C0F196);
    $display("dut4 send nibbles 6,9,1,F,0,C,3,A expect 0xa3c0f196");
    for (int j = 0; j < 4; j++) send4($urandom);
    idle(4);
    chk("sb4_empty", 64'(q4.size()), 64'd0);

    // Gaps in svalid after beats 7 and 20 do not disturb assembly.
    send1(32'h12345678, 1'b1, 7, 20, 1'b0);
    idle(4);
    chk("gap_sb_empty", 64'(q1.size()), 64'd0);
    chk("gap_level", 64'(lv1), 64'd0);

    // Overflow: no consumer, five packets, the fifth is dropped.
    r1 = 1'b0;
    for (int p = 1; p <= 5; p++) send1(32'(p), (p <= 4), -1, -1, 1'b0);
    @(posedge clk); #1;
    s1_valid = 1'b0;
    @(negedge clk);
    chk("ovf_pulse", 64'(ov1), 64'd1);
    chk("ovf_drop_count", 64'(dc1), 64'd1);
    chk("ovf_level", 64'(lv1), 64'd4);
    chk("ovf_head", 64'(f1_data), 64'd1);
    @(negedge clk);
    chk("ovf_pulse_end", 64'(ov1), 64'd0);
    drain1();

    // Full FIFO: the last beat of packet 6 coincides with a pop, so nothing is dropped.
    @(posedge clk); #1;
    r1 = 1'b0;
    for (int p = 1; p <= 4; p++) send1(32'(p), 1'b1, -1, -1, 1'b0);
    send1(32'd6, 1'b1, -1, -1, 1'b1);
    @(posedge clk); #1;
    r1 = 1'b0;
    s1_valid = 1'b0;
    @(negedge clk);
    chk("fullpop_level", 64'(lv1), 64'd4);
    chk("fullpop_overflow", 64'(ov1), 64'd0);
    chk("fullpop_drop", 64'(dc1), 64'd1);
    chk("fullpop_head", 64'(f1_data), 64'd2);
    drain1();
    chk("fullpop_sb_empty", 64'(q1.size()), 64'd0);

    // Reset mid-packet: the partial packet disappears and the counter clears.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s1_valid = 1'b1;
      s1_data  = 1'($urandom);
    end
    @(posedge clk); #1;
    aresetn  = 1'b0;
    s1_valid = 1'b1;
    s1_data  = 1'b1;
    @(posedge clk); #1;
    aresetn  = 1'b1;
    s1_valid = 1'b0;
    @(negedge clk);
    chk("midrst_drop", 64'(dc1), 64'd0);
    chk("midrst_level", 64'(lv1), 64'd0);
    send1(32'hDEADBEEF, 1'b1, -1, -1, 1'b0);
    idle(6);
    chk("midrst_sb_empty", 64'(q1.size()), 64'd0);
    chk("midrst_level_end", 64'(lv1), 64'd0);
    chk("midrst_drop_end", 64'(dc1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
